mbe_share_arbiter: RTL

- Round-robin arbiter that shares one Modified-Booth (MBE) multiplier among NREQ requesters.
- Each requester has a valid/ready request port carrying two signed operands, and a valid/ready response port returning the product.
- The block registers the operands into the multiplier, waits the multiplier latency, captures the product and returns it to the requester that was granted.
- It sits between the testbench or upstream agents and the MBE instance. The MBE itself is instantiated outside this block and connected through the mul_* ports.

---
 rtl/mbe_share_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mbe_share_arbiter.sv
// Round-robin front end that time-shares one external MBE multiplier.
// Operands are latched at grant; the product returns on the owner's port.
module mbe_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int LAT  = 1,
  localparam int IW  = $clog2(NREQ),
  localparam int CW  = $clog2(LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [2*W-1:0]    rsp_data,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p,
  output logic              busy,
  output logic [IW-1:0]     grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            found;
  logic            accept;
  logic            calc_done;
  logic            rsp_hs;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] gid_oh;
  int              j;

  // Search starts at ptr so the last owner has lowest priority.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j   = (int'(ptr) + k) % NREQ;
      idx = IW'(j);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_oh    = NREQ'(1) << win;
  assign gid_oh    = NREQ'(1) << grant_id;
  assign accept    = (state == IDLE) && found;
  assign calc_done = (state == CALC) && (cnt == '0);
  assign rsp_hs    = (state == SEND) && rsp_ready[grant_id];
  assign busy      = (state != IDLE);

  assign req_ready = (accept && rst) ? win_oh : '0;

  assign ptr_nxt = (grant_id == IW'(NREQ - 1)) ?
                   '0 : grant_id + IW'(1);

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == IDLE): if (accept)    state_n = CALC;
      (state == CALC): if (calc_done) state_n = SEND;
      (state == SEND): if (rsp_hs)    state_n = IDLE;
      default:                        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      grant_id  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else begin
      if (accept) begin
        mul_a    <= req_a[win*W +: W];
        mul_b    <= req_b[win*W +: W];
        grant_id <= win;
        cnt      <= CW'(LAT - 1);
      end
      if (state == CALC && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (calc_done) begin
        rsp_data  <= mul_p;
        rsp_valid <= gid_oh;
      end
      if (rsp_hs) begin
        rsp_valid <= '0;
        ptr       <= ptr_nxt;
      end
    end
  end

endmodule
